pri_decoder: RTL
================

PRI_DECODER -- requirements
Module: pri_decoder

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, meaning: cycles each decoded one-hot word is driven (legal range 1..255).
REQ-002 Parameter DEPTH, default 4, meaning: input FIFO entries (power of 2, minimum 2).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  encoded index offered.
REQ-006 in_idx  input  2  encoded line index (0..3), same encoding as the team's 4-to-2 priority encoder output.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 out_valid  output  1  out_onehot carries a decoded word.
REQ-009 out_onehot  output  4  one-hot decode of the current index; all-zero when out_valid is 0.
REQ-010 fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-011 Transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; the word is pushed into the FIFO.
REQ-012 in_ready SHALL be 1 exactly when fifo_level < DEPTH; a push with the FIFO full SHALL never occur, even if a pop happens in the same cycle.
REQ-013 FSM SHALL have two states: IDLE and DRIVE.
REQ-014 IDLE: out_valid=0, out_onehot=0; if the FIFO is non-empty, pop the head, register out_onehot = 1 << idx, load the hold counter with HOLD_CYCLES-1, go to DRIVE.
REQ-015 DRIVE: out_valid=1, out_onehot constant; hold counter decrements each cycle.
REQ-016 At hold counter 0 in DRIVE: if the FIFO is non-empty, pop and load the next word with no bubble cycle, staying in DRIVE; otherwise go to IDLE.
REQ-017 Latency: a word accepted into an empty FIFO with the FSM in IDLE at edge t SHALL appear on out_onehot after edge t+1 and remain for exactly HOLD_CYCLES cycles.
REQ-018 Simultaneous push and pop SHALL leave fifo_level unchanged and preserve order; words SHALL be output strictly FIFO-ordered.
REQ-019 FIFO pointers SHALL wrap modulo DEPTH; fifo_level SHALL distinguish full (DEPTH) from empty (0).
REQ-020 HOLD_CYCLES=1 SHALL produce back-to-back single-cycle one-hot words while the FIFO stays non-empty.
REQ-021 out_onehot SHALL always have exactly one bit set when out_valid=1 and zero bits otherwise.

Reset
REQ-022 rst_n low SHALL asynchronously force: FSM IDLE, FIFO empty (fifo_level=0), out_valid=0, out_onehot=0, hold counter 0, in_ready=1 on the first rising edge after deassertion.
REQ-023 Reset asserted mid-DRIVE SHALL drop out_valid immediately and discard all buffered words; no word from before reset SHALL appear afterwards.

Configuration
REQ-024 Macro PRI_DECODER_HITCNT_EN defined: extra output hit_cnt (32 bits, 4 lanes of 8) where lane i counts words decoded to line i, incrementing on the load cycle, saturating at 255, reset to 0.
REQ-025 Macro undefined: hit_cnt port and counters SHALL be absent; all other behaviour identical.

Structure
REQ-026 Package pri_dec_pkg SHALL hold: typedef idx_t (2-bit), typedef onehot_t (4-bit), NUM_LINES=4, state enum {IDLE, DRIVE}.
REQ-027 FIFO SHALL be a sub-module pri_dec_fifo (parameter DEPTH, push/pop/level/head ports); FSM, counter and decode stay in pri_decoder.

Verification
REQ-028 Reset, then single push idx=2 -> out_onehot=4'b0100, out_valid=1 for exactly 4 cycles starting one cycle after accept, then 0.
REQ-029 Push idx 0,1,2,3 back-to-back (DEPTH=4, HOLD=4) -> outputs 0001,0010,0100,1000, each 4 cycles, no bubbles, in order.
REQ-030 Hold in_valid=1 continuously -> fifo_level reaches 4, in_ready=0, no word lost or duplicated; in_ready returns 1 after the next pop.
REQ-031 HOLD_CYCLES=1 with continuous stream idx=3,0 -> 1000 then 0001 in consecutive cycles.
REQ-032 Assert rst_n low during DRIVE with 3 words buffered -> out_valid=0 immediately, fifo_level=0, nothing emitted after release.
REQ-033 With PRI_DECODER_HITCNT_EN, 300 words of idx=1 -> lane 1 reads 255, other lanes 0.

Source files
------------

// File: rtl/pri_dec_pkg.sv
// Shared types for the priority decoder: line index, one-hot word and FSM state.
package pri_dec_pkg;

    localparam int NUM_LINES = 4;

    typedef logic [1:0]           idx_t;
    typedef logic [NUM_LINES-1:0] onehot_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_e;

    function automatic onehot_t decode_idx(input idx_t idx);
        return onehot_t'(1) << idx;
    endfunction

endpackage

// File: rtl/pri_dec_fifo.sv
// Small index FIFO; level counts 0..DEPTH so full and empty stay distinct.
module pri_dec_fifo
    import pri_dec_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  idx_t                   data_i,
    output idx_t                   head_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   level_q;
    idx_t          mem_q [DEPTH];
    logic          do_push, do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    // Guard against a push into a full FIFO even when a pop coincides.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_q];
    assign level_o = level_q;

endmodule

// File: rtl/pri_decoder.sv
// Buffered index-to-one-hot decoder; each word is held for HOLD_CYCLES cycles.
// Optional per-line hit counters are enabled with PRI_DECODER_HITCNT_EN.
module pri_decoder
    import pri_dec_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  idx_t                   in_idx,
    output logic                   in_ready,
    output logic                   out_valid,
    output onehot_t                out_onehot,
    output logic [$clog2(DEPTH):0] fifo_level
`ifdef PRI_DECODER_HITCNT_EN
    ,
    output logic [31:0]            hit_cnt
`endif
);

    localparam logic [7:0] HOLD_M1 = 8'(HOLD_CYCLES - 1);

    state_e     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    onehot_t    onehot_q, onehot_d;
    logic       load;
    logic       fifo_push, fifo_full, fifo_empty;
    idx_t       fifo_head;

    assign in_ready  = ~fifo_full;
    assign fifo_push = in_valid & in_ready;

    pri_dec_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .pop_i   (load),
        .data_i  (in_idx),
        .head_o  (fifo_head),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            onehot_q <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            onehot_q <= onehot_d;
        end
    end

    // A load pops the FIFO head; at hold 0 the next word loads with no bubble.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        onehot_d = onehot_q;
        load     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    load    = 1'b1;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (hold_q != 8'd0) begin
                    hold_d = hold_q - 8'd1;
                end else if (!fifo_empty) begin
                    load = 1'b1;
                end else begin
                    state_d  = IDLE;
                    onehot_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            hold_d   = HOLD_M1;
            onehot_d = decode_idx(fifo_head);
        end
    end

    always_comb begin
        out_valid  = (state_q == DRIVE);
        out_onehot = (state_q == DRIVE) ? onehot_q : '0;
    end

`ifdef PRI_DECODER_HITCNT_EN
    logic [7:0] hit_q [NUM_LINES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LINES; i++) hit_q[i] <= '0;
        end else if (load && hit_q[fifo_head] != 8'hFF) begin
            hit_q[fifo_head] <= hit_q[fifo_head] + 8'd1;
        end
    end

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_hit
        assign hit_cnt[8*g +: 8] = hit_q[g];
    end
`endif

endmodule
